// File: rtl/pipe_scoreboard_if.sv
// Issue/operand bundle between the ID stage and pipe_scoreboard.
// master = ID-side driver, slave = the scoreboard itself.
interface pipe_scoreboard_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32
);
  logic                           issue_valid;
  logic [REG_ADDR_W-1:0]          issue_rd;
  logic                           issue_we;
  logic                           issue_is_load;
  logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr;
  logic [NUM_SRC-1:0]             src_used;
  logic [NUM_STAGES*DATA_W-1:0]   stage_data;
  logic                           hold;
  logic                           flush;
  logic                           stall;
  logic [NUM_SRC-1:0]             fwd_hit;
  logic [NUM_SRC*DATA_W-1:0]      fwd_data;
  logic [CNT_W-1:0]               perf_stall_cnt;
  logic [CNT_W-1:0]               perf_fwd_cnt;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_is_load,
    output src_addr, src_used, stage_data, hold, flush,
    input  stall, fwd_hit, fwd_data, perf_stall_cnt, perf_fwd_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_is_load,
    input  src_addr, src_used, stage_data, hold, flush,
    output stall, fwd_hit, fwd_data, perf_stall_cnt, perf_fwd_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Hazard detection and operand forwarding for an in-order pipeline of NUM_STAGES after ID.
// Optional performance counters are built when SCB_PERF_CNT_EN is defined.
module pipe_scoreboard #(
  parameter int unsigned NUM_STAGES       = 3,
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned LOAD_READY_STAGE = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_scoreboard_if.slave   bus
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } entry_t;

  entry_t [NUM_STAGES-1:0]             e_q, e_d;
  logic                                flush_pend_q, flush_pend_d;

  logic [NUM_SRC-1:0]                  found_c;
  logic [NUM_SRC-1:0]                  hit_c;
  logic [NUM_SRC-1:0]                  src_haz_c;
  logic [NUM_SRC-1:0][DATA_W-1:0]      data_c;
  logic                                hazard_c;
  logic                                stall_c;
  logic                                accept_c;

  // Per port: the youngest matching in-flight writer decides forward vs. hazard
  always_comb begin
    found_c   = '0;
    hit_c     = '0;
    src_haz_c = '0;
    data_c    = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        if (!found_c[s] && bus.src_used[s]
            && (bus.src_addr[s*REG_ADDR_W +: REG_ADDR_W] != '0)
            && e_q[i].v && e_q[i].we
            && (e_q[i].rd == bus.src_addr[s*REG_ADDR_W +: REG_ADDR_W])) begin
          found_c[s] = 1'b1;
          if (!e_q[i].ld || (i >= int'(LOAD_READY_STAGE))) begin
            hit_c[s]  = 1'b1;
            data_c[s] = bus.stage_data[i*DATA_W +: DATA_W];
          end else begin
            src_haz_c[s] = 1'b1;
          end
        end
      end
    end
  end

  assign hazard_c = |src_haz_c;
  assign stall_c  = bus.hold | hazard_c;
  assign accept_c = bus.issue_valid & ~stall_c & ~(bus.flush | flush_pend_q);

  assign bus.stall    = stall_c;
  assign bus.fwd_hit  = hit_c;
  assign bus.fwd_data = data_c;

  // Shift the in-flight record unless held; a held flush is deferred to the next advance
  always_comb begin
    e_d          = e_q;
    flush_pend_d = flush_pend_q;
    if (!bus.hold) begin
      e_d[0] = '0;
      if (accept_c) begin
        e_d[0].v  = 1'b1;
        e_d[0].rd = bus.issue_rd;
        e_d[0].we = bus.issue_we;
        e_d[0].ld = bus.issue_is_load;
      end
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
        e_d[i] = e_q[i-1];
      end
      flush_pend_d = 1'b0;
    end else if (bus.flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q          <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      e_q          <= e_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef SCB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters, frozen while held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!bus.hold) begin
      if (hazard_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (accept_c && (|hit_c) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_fwd_cnt   = fwd_cnt_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: default 3-stage build and a 5-stage/3-port build.
// Counter expectations follow SCB_PERF_CNT_EN.
module tb_pipe_scoreboard;

`ifdef SCB_PERF_CNT_EN
  localparam int unsigned PERF_ON = 1;
`else
  localparam int unsigned PERF_ON = 0;
`endif

  localparam logic [95:0]  A_SD = {32'hCCCC_0002, 32'hBBBB_0001, 32'h0000_1234};
  localparam logic [159:0] B_SD = {32'hD000_0004, 32'hD000_0003, 32'hD000_0002,
                                   32'hD000_0001, 32'hD000_0000};

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_scoreboard_if #(.NUM_STAGES(3), .NUM_SRC(2), .REG_ADDR_W(5), .DATA_W(32), .CNT_W(32)) a_if ();
  pipe_scoreboard #(.NUM_STAGES(3), .NUM_SRC(2), .REG_ADDR_W(5), .DATA_W(32),
                    .LOAD_READY_STAGE(1), .CNT_W(32))
    dut_a (.clk(clk), .reset(reset_a), .bus(a_if));

  pipe_scoreboard_if #(.NUM_STAGES(5), .NUM_SRC(3), .REG_ADDR_W(5), .DATA_W(32), .CNT_W(32)) b_if ();
  pipe_scoreboard #(.NUM_STAGES(5), .NUM_SRC(3), .REG_ADDR_W(5), .DATA_W(32),
                    .LOAD_READY_STAGE(3), .CNT_W(32))
    dut_b (.clk(clk), .reset(reset_b), .bus(b_if));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_if.issue_valid = 1'b0; a_if.issue_rd = 5'd0; a_if.issue_we = 1'b0; a_if.issue_is_load = 1'b0;
    a_if.src_addr = '0; a_if.src_used = '0; a_if.hold = 1'b0; a_if.flush = 1'b0;
  endtask

  task automatic a_issue(input logic [4:0] rd, input logic ld);
    a_if.issue_valid = 1'b1; a_if.issue_rd = rd; a_if.issue_we = 1'b1; a_if.issue_is_load = ld;
  endtask

  task automatic a_drain();
    a_idle();
    repeat (3) tick();
  endtask

  task automatic b_idle();
    b_if.issue_valid = 1'b0; b_if.issue_rd = 5'd0; b_if.issue_we = 1'b0; b_if.issue_is_load = 1'b0;
    b_if.src_addr = '0; b_if.src_used = '0; b_if.hold = 1'b0; b_if.flush = 1'b0;
  endtask

  initial begin
    a_idle(); b_idle();
    a_if.stage_data = A_SD;
    b_if.stage_data = B_SD;
    reset_a = 1'b1; reset_b = 1'b1;
    tick(); tick();
    reset_a = 1'b0; reset_b = 1'b0;

    // Reset state
    #1;
    chk("rst_stall", 64'(a_if.stall), 64'd0);
    chk("rst_hit", 64'(a_if.fwd_hit), 64'd0);
    chk("rst_data", 64'(a_if.fwd_data), 64'd0);
    a_if.hold = 1'b1; #1;
    chk("rst_hold_stall", 64'(a_if.stall), 64'd1);
    a_if.hold = 1'b0;

    // ALU chain: forward from EX
    a_issue(5'd5, 1'b0);
    tick();
    a_idle(); a_if.src_addr = {5'd0, 5'd5}; a_if.src_used = 2'b01; #1;
    chk("alu_stall", 64'(a_if.stall), 64'd0);
    chk("alu_hit", 64'(a_if.fwd_hit), 64'd1);
    chk("alu_data", 64'(a_if.fwd_data[31:0]), 64'h1234);

    // Load-use on port 1 from a clean reset
    a_drain();
    reset_a = 1'b1; tick(); reset_a = 1'b0;
    a_issue(5'd7, 1'b1);
    tick();
    a_issue(5'd9, 1'b0); a_if.src_addr = {5'd7, 5'd0}; a_if.src_used = 2'b10; #1;
    chk("ld_stall1", 64'(a_if.stall), 64'd1);
    tick();
    chk("ld_stall2", 64'(a_if.stall), 64'd0);
    chk("ld_hit", 64'(a_if.fwd_hit), 64'h2);
    chk("ld_data", 64'(a_if.fwd_data[63:32]), 64'hBBBB_0001);
    chk("ld_perf_stall", 64'(a_if.perf_stall_cnt), 64'(PERF_ON));
    tick();
    a_idle(); #1;
    chk("ld_perf_fwd", 64'(a_if.perf_fwd_cnt), 64'(PERF_ON));

    // Youngest match wins
    a_drain();
    a_issue(5'd3, 1'b0); tick();
    a_idle(); tick();
    a_issue(5'd3, 1'b0); tick();
    a_idle(); a_if.src_addr = {5'd3, 5'd3}; a_if.src_used = 2'b11; #1;
    chk("young_hit", 64'(a_if.fwd_hit), 64'h3);
    chk("young_data", 64'(a_if.fwd_data), {32'h0000_1234, 32'h0000_1234});
    tick();
    chk("young_shift_data", 64'(a_if.fwd_data[31:0]), 64'hBBBB_0001);

    // x0 and unused ports
    a_drain();
    a_issue(5'd0, 1'b0); tick();
    a_idle(); a_if.src_used = 2'b11; #1;
    chk("x0_hit", 64'(a_if.fwd_hit), 64'd0);
    chk("x0_stall", 64'(a_if.stall), 64'd0);
    chk("x0_data", 64'(a_if.fwd_data), 64'd0);
    a_idle(); a_issue(5'd4, 1'b1); tick();
    a_idle(); a_if.src_addr = {5'd4, 5'd4}; #1;
    chk("unused_stall", 64'(a_if.stall), 64'd0);
    chk("unused_hit", 64'(a_if.fwd_hit), 64'd0);
    a_if.src_used = 2'b01; #1;
    chk("used_ld_stall", 64'(a_if.stall), 64'd1);

    // Hold with flush pulsed in the first held cycle
    a_drain();
    a_issue(5'd6, 1'b0); tick();
    a_issue(5'd8, 1'b0); a_if.hold = 1'b1; a_if.flush = 1'b1;
    a_if.src_addr = {5'd0, 5'd6}; a_if.src_used = 2'b01; #1;
    chk("hold_stall1", 64'(a_if.stall), 64'd1);
    tick();
    a_if.flush = 1'b0; #1;
    chk("hold_stall2", 64'(a_if.stall), 64'd1);
    chk("hold_frozen2", 64'(a_if.fwd_data[31:0]), 64'h1234);
    tick();
    chk("hold_frozen3", 64'(a_if.fwd_data[31:0]), 64'h1234);
    tick();
    a_if.hold = 1'b0; #1;
    chk("hold_release_stall", 64'(a_if.stall), 64'd0);
    tick();
    a_if.src_addr = {5'd8, 5'd6}; a_if.src_used = 2'b11; #1;
    chk("hold_shift_data", 64'(a_if.fwd_data[31:0]), 64'hBBBB_0001);
    chk("hold_flushed_hit", 64'(a_if.fwd_hit), 64'h1);
    tick();
    chk("hold_pend_cleared", 64'(a_if.fwd_hit[1]), 64'd1);
    chk("hold_pend_data", 64'(a_if.fwd_data[63:32]), 64'h1234);

    // Flush during a hazard: stall reported, consumer not accepted
    a_drain();
    a_issue(5'd7, 1'b1); tick();
    a_issue(5'd12, 1'b0); a_if.flush = 1'b1;
    a_if.src_addr = {5'd0, 5'd7}; a_if.src_used = 2'b01; #1;
    chk("flush_haz_stall", 64'(a_if.stall), 64'd1);
    tick();
    a_idle(); a_if.src_addr = {5'd12, 5'd0}; a_if.src_used = 2'b10; #1;
    chk("flush_haz_noissue", 64'(a_if.fwd_hit), 64'd0);

    // Deep pipe: load-use stalls exactly LOAD_READY_STAGE=3 cycles on port 2
    b_if.issue_valid = 1'b1; b_if.issue_rd = 5'd10; b_if.issue_we = 1'b1; b_if.issue_is_load = 1'b1;
    tick();
    b_if.issue_rd = 5'd13; b_if.issue_is_load = 1'b0;
    b_if.src_addr = {5'd10, 5'd0, 5'd0}; b_if.src_used = 3'b100; #1;
    chk("b_stall1", 64'(b_if.stall), 64'd1);
    tick();
    chk("b_stall2", 64'(b_if.stall), 64'd1);
    tick();
    chk("b_stall3", 64'(b_if.stall), 64'd1);
    tick();
    chk("b_stall4", 64'(b_if.stall), 64'd0);
    chk("b_hit", 64'(b_if.fwd_hit), 64'h4);
    chk("b_data", 64'(b_if.fwd_data[95:64]), 64'hD000_0003);
    chk("b_perf_stall", 64'(b_if.perf_stall_cnt), 64'(3 * PERF_ON));

    // Reset in the 2nd stall cycle clears tracking
    b_idle();
    repeat (5) tick();
    b_if.issue_valid = 1'b1; b_if.issue_rd = 5'd11; b_if.issue_we = 1'b1; b_if.issue_is_load = 1'b1;
    tick();
    b_if.issue_rd = 5'd14; b_if.issue_is_load = 1'b0;
    b_if.src_addr = {5'd0, 5'd11, 5'd0}; b_if.src_used = 3'b010; #1;
    chk("b_rst_stall1", 64'(b_if.stall), 64'd1);
    tick();
    chk("b_rst_stall2", 64'(b_if.stall), 64'd1);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0; #1;
    chk("b_rst_cleared", 64'(b_if.stall), 64'd0);
    chk("b_rst_hit", 64'(b_if.fwd_hit), 64'd0);
    chk("b_rst_perf", 64'(b_if.perf_stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
